// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and types for the PS/2 key tracker
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} frame_state_t;

  typedef struct packed {
    logic       valid;
    logic       ext;
    logic [7:0] code;
  } held_entry_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 synchroniser, clock glitch filter and 11-bit frame receiver
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err,
  output logic       timeout_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_c, sync_d;
  logic                   c_s, d_s, c_filt, change, fall;
  logic [FW-1:0]          flt_cnt;

  frame_state_t state, next_state;
  logic [10:0]  bits;
  logic [3:0]   bit_idx;
  logic [TW-1:0] idle_cnt;
  logic         idle_hit, frame_ok;

  assign c_s    = sync_c[SYNC_STAGES-1];
  assign d_s    = sync_d[SYNC_STAGES-1];
  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  assign change = (c_s != c_filt) && (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall   = change && c_filt;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      sync_c  <= '1;
      sync_d  <= '1;
      c_filt  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      sync_c <= {sync_c[SYNC_STAGES-2:0], PS2C};
      sync_d <= {sync_d[SYNC_STAGES-2:0], PS2D};
      if (c_s == c_filt) begin
        flt_cnt <= '0;
      end else if (change) begin
        c_filt  <= c_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign idle_hit = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetN) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fall && !d_s) next_state = SHIFT;
      SHIFT: begin
        if (fall && bit_idx == 4'd10) next_state = CHECK;
        else if (!fall && idle_hit)   next_state = IDLE;
      end
      CHECK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      bits     <= '0;
      bit_idx  <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (fall && !d_s) begin
            bits[0] <= 1'b0;
            bit_idx <= 4'd1;
          end
        end
        SHIFT: begin
          if (fall) begin
            bits[bit_idx] <= d_s;
            bit_idx       <= bit_idx + 4'd1;
            idle_cnt      <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: idle_cnt <= '0;
      endcase
    end
  end

  assign frame_ok  = !bits[0] && bits[10] && (^bits[9:1]);
  assign byte_data = bits[8:1];

  always_comb begin
    byte_valid  = 1'b0;
    byte_err    = 1'b0;
    timeout_err = 1'b0;
    case (state)
      CHECK: begin
        byte_valid = frame_ok;
        byte_err   = !frame_ok;
      end
      SHIFT:   timeout_err = !fall && idle_hit;
      default: ;
    endcase
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 prefix decoder with held-key table and query port
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_HELD       = 4
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          PS2C,
  input  logic                          PS2D,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic                          ev_repeat,
  input  logic [7:0]                    query_code,
  input  logic                          query_ext,
  output logic                          query_held,
  output logic [$clog2(MAX_HELD+1)-1:0] held_count,
  output logic                          err_parity,
  output logic                          err_timeout,
  output logic                          held_ovf
);

  localparam int CW = $clog2(MAX_HELD + 1);

  logic       byte_valid, byte_err, timeout_err;
  logic [7:0] byte_data;
  logic       ext_pend, brk_pend;

  held_entry_t          tbl [MAX_HELD];
  logic [MAX_HELD-1:0]  byte_hit_v, ev_hit_v, q_hit_v, free_sel;
  logic                 found_free, full, ev_hit;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .resetN     (resetN),
    .PS2C       (PS2C),
    .PS2D       (PS2D),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err),
    .timeout_err(timeout_err)
  );

  always_comb begin
    byte_hit_v = '0;
    ev_hit_v   = '0;
    q_hit_v    = '0;
    free_sel   = '0;
    found_free = 1'b0;
    held_count = '0;
    for (int i = 0; i < MAX_HELD; i++) begin
      byte_hit_v[i] = tbl[i].valid && tbl[i].code == byte_data  && tbl[i].ext == ext_pend;
      ev_hit_v[i]   = tbl[i].valid && tbl[i].code == ev_code    && tbl[i].ext == ev_ext;
      q_hit_v[i]    = tbl[i].valid && tbl[i].code == query_code && tbl[i].ext == query_ext;
      if (!tbl[i].valid && !found_free) begin
        free_sel[i] = 1'b1;
        found_free  = 1'b1;
      end
      held_count = held_count + CW'(tbl[i].valid);
    end
  end

  assign full       = !found_free;
  assign ev_hit     = |ev_hit_v;
  assign query_held = |q_hit_v;

  // Prefix bytes only arm flags; the terminal byte carries them into one event.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      ev_valid    <= 1'b0;
      ev_code     <= '0;
      ev_ext      <= 1'b0;
      ev_break    <= 1'b0;
      ev_repeat   <= 1'b0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      err_parity  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ev_valid    <= 1'b0;
      err_parity  <= byte_err;
      err_timeout <= timeout_err;
      if (byte_err || timeout_err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (byte_data == PS2_BREAK) begin
          brk_pend <= 1'b1;
        end else begin
          ev_valid  <= 1'b1;
          ev_code   <= byte_data;
          ev_ext    <= ext_pend;
          ev_break  <= brk_pend;
          ev_repeat <= !brk_pend && (|byte_hit_v);
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < MAX_HELD; i++) tbl[i] <= '0;
      held_ovf <= 1'b0;
    end else begin
      if (ev_valid) begin
        for (int i = 0; i < MAX_HELD; i++) begin
          if (!ev_break && !ev_hit && free_sel[i])
            tbl[i] <= {1'b1, ev_ext, ev_code};
          else if (ev_break && ev_hit_v[i])
            tbl[i].valid <= 1'b0;
        end
      end
      if (ev_valid && !ev_break && !ev_hit && full)
        held_ovf <= 1'b1;
      else if (held_count == '0)
        held_ovf <= 1'b0;
    end
  end

endmodule
